// File: rtl/game_pkg.sv
// Shared types and default constants for the modulus-game controller.
// Contents: the game FSM state type, datapath widths, default timing and
// difficulty constants, and a helper that qualifies a random divisor.
package game_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_GEN   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_JUDGE = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  localparam int unsigned DIVIDEND_W = 7;
  localparam int unsigned DIVISOR_W  = 4;
  localparam int unsigned RATE_W     = 27;
  localparam int unsigned LEVEL_W    = 4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 120000;
  localparam int unsigned DEF_BASE_RATE       = 36000000;
  localparam int unsigned DEF_RATE_STEP       = 3000000;
  localparam int unsigned DEF_MIN_RATE        = 6000000;
  localparam int unsigned DEF_STREAK_LEN      = 5;
  localparam int unsigned DEF_MAX_LEVEL       = 9;

  // Usable divisors are 2..9; anything else is resampled.
  function automatic logic divisor_ok(input logic [DIVISOR_W-1:0] d);
    return (d >= 4'd2) && (d <= 4'd9);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Check-button conditioner: 2-flop synchronizer, stability counter and
// falling-edge detector producing a single press pulse per press.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous, active-high
//   btn_n     in  raw active-low button, asynchronous
//   press_evt out one-cycle pulse on a debounced high->low transition
// Raw edge (stable thereafter) to press_evt is DEBOUNCE_CYCLES+3 cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press_evt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d, db_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized input disagrees with the
  // debounced level; any agreement restarts the stability window.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_q      <= 1'b1;
      db_prev_q <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_n;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      press_q   <= db_prev_q & ~db_q;
    end
  end

  assign press_evt = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Central modulus-game controller: problem generation, answer judging,
// health reward/penalty pulses, difficulty ramp and restart from game over.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   check_btn_n     raw active-low check button (asynchronous)
//   answer_correct  judge result from modulus_check
//   health_zero     health exhausted
//   rng_dividend/rng_divisor  random problem candidates
//   dividend/divisor          latched current problem
//   gain_health/lose_health/restart  one-cycle pulses
//   deduct_rate     health decay period for the current level
//   level           difficulty level 0..MAX_LEVEL
//   game_over       high while in ST_OVER
// All outputs are registered.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned BASE_RATE       = DEF_BASE_RATE,
  parameter int unsigned RATE_STEP       = DEF_RATE_STEP,
  parameter int unsigned MIN_RATE        = DEF_MIN_RATE,
  parameter int unsigned STREAK_LEN      = DEF_STREAK_LEN,
  parameter int unsigned MAX_LEVEL       = DEF_MAX_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  check_btn_n,
  input  logic                  answer_correct,
  input  logic                  health_zero,
  input  logic [DIVIDEND_W-1:0] rng_dividend,
  input  logic [DIVISOR_W-1:0]  rng_divisor,
  output logic [DIVIDEND_W-1:0] dividend,
  output logic [DIVISOR_W-1:0]  divisor,
  output logic                  gain_health,
  output logic                  lose_health,
  output logic                  restart,
  output logic [RATE_W-1:0]     deduct_rate,
  output logic [LEVEL_W-1:0]    level,
  output logic                  game_over
);

  localparam int unsigned STREAK_W = $clog2(STREAK_LEN + 1);

  logic press_evt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_n    (check_btn_n),
    .press_evt(press_evt)
  );

  game_state_t           state_q, state_d;
  logic [DIVIDEND_W-1:0] dividend_q, dividend_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [RATE_W-1:0]     rate_q, rate_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  gain_q, gain_d, lose_q, lose_d;
  logic                  restart_q, restart_d, over_q;

  // One extra bit so a step larger than the current rate shows up as a
  // set MSB instead of wrapping past the floor.
  logic [RATE_W:0]   rate_sub;
  logic [RATE_W-1:0] rate_lvlup;

  assign rate_sub   = {1'b0, rate_q} - (RATE_W + 1)'(RATE_STEP);
  assign rate_lvlup = (rate_sub[RATE_W] || (rate_sub < (RATE_W + 1)'(MIN_RATE)))
                      ? RATE_W'(MIN_RATE) : rate_sub[RATE_W-1:0];

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rate_d     = rate_q;
    level_d    = level_q;
    streak_d   = streak_q;
    gain_d     = 1'b0;
    lose_d     = 1'b0;
    restart_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        level_d  = '0;
        streak_d = '0;
        rate_d   = RATE_W'(BASE_RATE);
        state_d  = ST_GEN;
      end
      ST_GEN: begin
        if (divisor_ok(rng_divisor)) begin
          dividend_d = rng_dividend;
          divisor_d  = rng_divisor;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (health_zero)    state_d = ST_OVER;
        else if (press_evt) state_d = ST_JUDGE;
      end
      ST_JUDGE: begin
        if (health_zero) begin
          state_d = ST_OVER;
        end else if (answer_correct) begin
          gain_d  = 1'b1;
          state_d = ST_GEN;
          if (streak_q == STREAK_W'(STREAK_LEN - 1)) begin
            streak_d = '0;
            rate_d   = rate_lvlup;
            if (level_q < LEVEL_W'(MAX_LEVEL)) level_d = level_q + LEVEL_W'(1);
          end else begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else begin
          lose_d   = 1'b1;
          streak_d = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_OVER: begin
        if (press_evt) begin
          restart_d = 1'b1;
          state_d   = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      dividend_q <= '0;
      divisor_q  <= '0;
      rate_q     <= RATE_W'(BASE_RATE);
      level_q    <= '0;
      streak_q   <= '0;
      gain_q     <= 1'b0;
      lose_q     <= 1'b0;
      restart_q  <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rate_q     <= rate_d;
      level_q    <= level_d;
      streak_q   <= streak_d;
      gain_q     <= gain_d;
      lose_q     <= lose_d;
      restart_q  <= restart_d;
      over_q     <= (state_d == ST_OVER);
    end
  end

  assign dividend    = dividend_q;
  assign divisor     = divisor_q;
  assign gain_health = gain_q;
  assign lose_health = lose_q;
  assign restart     = restart_q;
  assign deduct_rate = rate_q;
  assign level       = level_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with small timing parameters and a
// transaction-level reference model of the scoring and difficulty rules.
module tb_game_sequencer;

  localparam int DEB   = 4;
  localparam int BASE  = 100;
  localparam int STEP  = 10;
  localparam int MINR  = 70;
  localparam int STRK  = 2;
  localparam int MAXL  = 3;
  localparam int LAT   = DEB + 5;  // raw press edge -> gain/lose pulse, in negedges

  logic       clk, reset, check_btn_n, answer_correct, health_zero;
  logic [6:0] rng_dividend, dividend;
  logic [3:0] rng_divisor, divisor, level;
  logic       gain_health, lose_health, restart, game_over;
  logic [26:0] deduct_rate;

  game_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .BASE_RATE(BASE), .RATE_STEP(STEP),
    .MIN_RATE(MINR), .STREAK_LEN(STRK), .MAX_LEVEL(MAXL)
  ) dut (
    .clk(clk), .reset(reset), .check_btn_n(check_btn_n),
    .answer_correct(answer_correct), .health_zero(health_zero),
    .rng_dividend(rng_dividend), .rng_divisor(rng_divisor),
    .dividend(dividend), .divisor(divisor), .gain_health(gain_health),
    .lose_health(lose_health), .restart(restart), .deduct_rate(deduct_rate),
    .level(level), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_level, m_rate, m_streak, exp_dividend, exp_divisor;

  task automatic model_reset();
    m_level = 0; m_rate = BASE; m_streak = 0;
  endtask

  task automatic model_judge(input bit correct);
    if (correct) begin
      m_streak++;
      if (m_streak == STRK) begin
        m_streak = 0;
        m_level  = (m_level + 1 > MAXL) ? MAXL : m_level + 1;
        m_rate   = (m_rate - STEP < MINR) ? MINR : m_rate - STEP;
      end
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic new_rng();
    rng_dividend = 7'($urandom);
    rng_divisor  = 4'($urandom_range(2, 9));
  endtask

  // Presses the button for low_cyc negedges, releases it, and watches the
  // pulses. rst_at / hz_at (negedge index, -1 = never) inject reset or
  // health_zero mid-sequence.
  task automatic press(input int low_cyc, input int rst_at, input int hz_at,
                       output int g, output int l, output int r, output int both,
                       output int first_g, output int first_l);
    g = 0; l = 0; r = 0; both = 0; first_g = -1; first_l = -1;
    check_btn_n = 1'b0;
    for (int i = 1; i <= low_cyc + DEB + 6; i++) begin
      @(negedge clk);
      if (gain_health) begin g++; if (first_g < 0) first_g = i; end
      if (lose_health) begin l++; if (first_l < 0) first_l = i; end
      if (restart) r++;
      if (gain_health && lose_health) both++;
      if (i == low_cyc) check_btn_n = 1'b1;
      if (i == rst_at) begin reset = 1'b1; check_btn_n = 1'b1; end
      if (i == rst_at + 1) reset = 1'b0;
      if (i == hz_at) health_zero = 1'b1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; check_btn_n = 1'b1; health_zero = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    model_reset();
    exp_dividend = rng_dividend; exp_divisor = rng_divisor;
  endtask

  // One press judged with the given answer; checks pulses and resulting state.
  task automatic judge_once(input bit correct, input string tag);
    int g, l, r, both, fg, fl;
    answer_correct = correct;
    new_rng();
    press(DEB + 8, -1, -1, g, l, r, both, fg, fl);
    model_judge(correct);
    if (correct) begin exp_dividend = rng_dividend; exp_divisor = rng_divisor; end
    checks++;
    if (g !== (correct ? 1 : 0) || l !== (correct ? 0 : 1) || both !== 0 || r !== 0) begin
      failures++;
      $display("FAIL %s pulses: gain=%0d lose=%0d both=%0d restart=%0d required gain=%0d lose=%0d",
               tag, g, l, both, r, correct ? 1 : 0, correct ? 0 : 1);
    end
    checks++;
    if ((correct ? fg : fl) !== LAT) begin
      failures++;
      $display("FAIL %s pulse_latency: got %0d required %0d", tag, correct ? fg : fl, LAT);
    end
    checks++;
    if (int'(dividend) !== exp_dividend || int'(divisor) !== exp_divisor) begin
      failures++;
      $display("FAIL %s problem: got %0d/%0d required %0d/%0d", tag, dividend, divisor,
               exp_dividend, exp_divisor);
    end
    checks++;
    if (int'(level) !== m_level || int'(deduct_rate) !== m_rate || game_over !== 1'b0) begin
      failures++;
      $display("FAIL %s difficulty: level=%0d rate=%0d over=%0b required level=%0d rate=%0d over=0",
               tag, level, deduct_rate, game_over, m_level, m_rate);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; check_btn_n = 1'b1; answer_correct = 1'b0; health_zero = 1'b0;
    rng_divisor = 4'd5; rng_dividend = 7'd37;
    repeat (3) @(negedge clk);
    checks++;
    if (dividend !== 7'd0 || divisor !== 4'd0 || deduct_rate !== 27'd100 || level !== 4'd0 ||
        gain_health !== 1'b0 || lose_health !== 1'b0 || restart !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: div=%0d dvs=%0d rate=%0d lvl=%0d g=%0b l=%0b r=%0b over=%0b required zeros, rate=100",
               dividend, divisor, deduct_rate, level, gain_health, lose_health, restart, game_over);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dividend !== 7'd0) begin
      failures++;
      $display("FAIL init_no_latch: dividend=%0d required 0", dividend);
    end
    @(negedge clk);
    checks++;
    if (dividend !== 7'd37 || divisor !== 4'd5 || deduct_rate !== 27'd100 || level !== 4'd0) begin
      failures++;
      $display("FAIL first_problem: %0d/%0d rate=%0d lvl=%0d required 37/5 rate=100 lvl=0",
               dividend, divisor, deduct_rate, level);
    end
  endtask

  task automatic test_gen_filter();
    logic [3:0] bad [5];
    logic [6:0] d;
    bad[0] = 4'd0; bad[1] = 4'd1; bad[2] = 4'd11; bad[3] = 4'd10;
    bad[4] = 4'($urandom_range(10, 15));
    reset = 1'b1; rng_divisor = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    foreach (bad[k]) begin
      rng_divisor = bad[k]; rng_dividend = 7'($urandom);
      repeat (3) @(negedge clk);
      checks++;
      if (dividend !== 7'd0 || divisor !== 4'd0) begin
        failures++;
        $display("FAIL gen_reject_%0d: %0d/%0d required 0/0", bad[k], dividend, divisor);
      end
    end
    d = 7'($urandom);
    rng_divisor = 4'd7; rng_dividend = d;
    @(negedge clk);
    checks++;
    if (dividend !== d || divisor !== 4'd7) begin
      failures++;
      $display("FAIL gen_accept: %0d/%0d required %0d/7", dividend, divisor, d);
    end
    model_reset();
    exp_dividend = d; exp_divisor = 7;
  endtask

  task automatic test_debounce();
    int l = 0, g = 0, gg, ll, r, both, fg, fl;
    answer_correct = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_btn_n = 1'b0;
      repeat ((k == 0) ? 2 : $urandom_range(1, DEB - 1)) begin
        @(negedge clk); l += lose_health; g += gain_health;
      end
      check_btn_n = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk); l += lose_health; g += gain_health;
      end
    end
    repeat (DEB + 6) begin @(negedge clk); l += lose_health; g += gain_health; end
    checks++;
    if (l !== 0 || g !== 0) begin
      failures++;
      $display("FAIL glitch_filter: lose=%0d gain=%0d required 0/0", l, g);
    end
    rng_dividend = 7'($urandom);
    press(1000, -1, -1, gg, ll, r, both, fg, fl);
    model_judge(1'b0);
    checks++;
    if (ll !== 1 || gg !== 0 || fl !== LAT) begin
      failures++;
      $display("FAIL held_press: lose=%0d gain=%0d first=%0d required 1/0/%0d", ll, gg, fl, LAT);
    end
    checks++;
    if (int'(dividend) !== exp_dividend) begin
      failures++;
      $display("FAIL held_press_dividend: got %0d required %0d", dividend, exp_dividend);
    end
  endtask

  task automatic test_correct();
    for (int k = 0; k < 8; k++) begin
      judge_once(1'b1, $sformatf("correct%0d", k));
      if (k == 1) begin
        checks++;
        if (level !== 4'd1 || deduct_rate !== 27'd90) begin
          failures++;
          $display("FAIL first_levelup: level=%0d rate=%0d required 1/90", level, deduct_rate);
        end
      end
    end
    checks++;
    if (level !== 4'd3 || deduct_rate !== 27'd70) begin
      failures++;
      $display("FAIL saturation: level=%0d rate=%0d required 3/70", level, deduct_rate);
    end
  endtask

  task automatic test_wrong();
    new_rng();
    apply_reset();
    judge_once(1'b1, "pre_wrong");
    judge_once(1'b0, "wrong");
    judge_once(1'b1, "after_wrong1");
    checks++;
    if (level !== 4'd0 || deduct_rate !== 27'd100) begin
      failures++;
      $display("FAIL streak_cleared: level=%0d rate=%0d required 0/100", level, deduct_rate);
    end
    judge_once(1'b1, "after_wrong2");
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) judge_once(1'($urandom), $sformatf("rand%0d", k));
  endtask

  task automatic over_and_restart(input int hz_at, input string tag);
    int g, l, r, both, fg, fl;
    answer_correct = 1'($urandom);
    press(DEB + 8, -1, hz_at, g, l, r, both, fg, fl);
    checks++;
    if (g !== 0 || l !== 0 || game_over !== 1'b1) begin
      failures++;
      $display("FAIL %s_over: gain=%0d lose=%0d over=%0b required 0/0/1", tag, g, l, game_over);
    end
    health_zero = 1'b0;
    new_rng();
    press(DEB + 8, -1, -1, g, l, r, both, fg, fl);
    model_reset();
    exp_dividend = rng_dividend; exp_divisor = rng_divisor;
    checks++;
    if (r !== 1 || g !== 0 || l !== 0) begin
      failures++;
      $display("FAIL %s_restart: restart=%0d gain=%0d lose=%0d required 1/0/0", tag, r, g, l);
    end
    checks++;
    if (level !== 4'd0 || deduct_rate !== 27'd100 || game_over !== 1'b0 ||
        int'(dividend) !== exp_dividend || int'(divisor) !== exp_divisor) begin
      failures++;
      $display("FAIL %s_newgame: lvl=%0d rate=%0d over=%0b prob=%0d/%0d required 0/100/0 %0d/%0d",
               tag, level, deduct_rate, game_over, dividend, divisor, exp_dividend, exp_divisor);
    end
  endtask

  task automatic test_over();
    judge_once(1'b1, "pre_over_a");
    judge_once(1'b1, "pre_over_b");
    over_and_restart(DEB + 3, "wait_hz");   // health_zero with press_evt in ST_WAIT
    judge_once(1'b1, "pre_over_c");
    over_and_restart(DEB + 4, "judge_hz");  // health_zero during ST_JUDGE
  endtask

  task automatic test_reset_in_judge();
    int g, l, r, both, fg, fl;
    judge_once(1'b1, "pre_rst_a");
    judge_once(1'b1, "pre_rst_b");
    answer_correct = 1'b1;
    new_rng();
    press(DEB + 8, DEB + 4, -1, g, l, r, both, fg, fl);
    model_reset();
    exp_dividend = rng_dividend; exp_divisor = rng_divisor;
    checks++;
    if (g !== 0 || l !== 0 || r !== 0) begin
      failures++;
      $display("FAIL reset_in_judge_pulses: gain=%0d lose=%0d restart=%0d required 0/0/0", g, l, r);
    end
    checks++;
    if (level !== 4'd0 || deduct_rate !== 27'd100 || int'(dividend) !== exp_dividend) begin
      failures++;
      $display("FAIL reset_in_judge_state: lvl=%0d rate=%0d div=%0d required 0/100/%0d",
               level, deduct_rate, dividend, exp_dividend);
    end
    judge_once(1'b1, "post_rst");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_gen_filter();
    test_debounce();
    test_correct();
    test_wrong();
    test_random();
    test_over();
    test_reset_in_judge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
